// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, clocks-per-bit constants and baud mapping.
// Used by both the 8N1 receiver and the transmitter.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      START   = 3'd1,
      DATA    = 3'd2,
      PARITY  = 3'd3,
      STOP    = 3'd4,
      CLEANUP = 3'd5
   } uart_state_t;

   localparam int CLKS_PER_BIT_9600  = 1042;
   localparam int CLKS_PER_BIT_19200 = 521;
   localparam int CLKS_PER_BIT_38400 = 261;
   localparam int CLKS_PER_BIT_57600 = 174;

   function automatic logic [10:0] baud_clks(input logic [1:0] sel,
                                             input int c00, input int c01,
                                             input int c10, input int c11);
      case (sel)
         2'b00:   baud_clks = 11'(c00);
         2'b01:   baud_clks = 11'(c01);
         2'b10:   baud_clks = 11'(c10);
         default: baud_clks = 11'(c11);
      endcase
   endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Per-bit cycle counter: counts 0..n_clks-1 while enabled, tick at n_clks-1.
// Latency: tick is combinational from the registered count; no backpressure.
module uart_bit_timer (
   input  logic        i_Clock,
   input  logic        i_Rst_L,
   input  logic        en,
   input  logic [10:0] n_clks,
   output logic [10:0] count,
   output logic        tick
);

   assign tick = en && (count == n_clks - 11'd1);

   // Held at zero while disabled so each frame starts on a fresh bit boundary.
   always_ff @(posedge i_Clock or negedge i_Rst_L) begin
      if (!i_Rst_L)
         count <= 11'd0;
      else if (!en || tick)
         count <= 11'd0;
      else
         count <= count + 11'd1;
   end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter (8E1/8O1 when UART_TX_PARITY_EN is defined); start bit 1 cycle after accept.
// Backpressure: o_Tx_Ready is high only in IDLE; i_Tx_DV outside IDLE is dropped, not queued.
module uart_tx #(
   parameter int CLKS_PER_BIT_9600  = uart_pkg::CLKS_PER_BIT_9600,
   parameter int CLKS_PER_BIT_19200 = uart_pkg::CLKS_PER_BIT_19200,
   parameter int CLKS_PER_BIT_38400 = uart_pkg::CLKS_PER_BIT_38400,
   parameter int CLKS_PER_BIT_57600 = uart_pkg::CLKS_PER_BIT_57600,
   parameter bit PARITY_ODD         = 1'b0
) (
   input  logic       i_Clock,
   input  logic       i_Rst_L,
   input  logic       i_Tx_DV,
   input  logic [7:0] i_Tx_Byte,
   input  logic [1:0] baud_select,
   output logic       o_Tx_Serial,
   output logic       o_Tx_Active,
   output logic       o_Tx_Done,
   output logic       o_Tx_Ready
);
   import uart_pkg::*;

   uart_state_t state;
   logic [7:0]  shift_reg;
   logic [10:0] n_lat;
   logic [2:0]  bit_idx;
   logic [10:0] bit_cnt;
   logic        bit_tick;

   // o_Tx_Active spans exactly the start..stop bits, so it doubles as the timer enable.
   uart_bit_timer u_bit_timer (
      .i_Clock (i_Clock),
      .i_Rst_L (i_Rst_L),
      .en      (o_Tx_Active),
      .n_clks  (n_lat),
      .count   (bit_cnt),
      .tick    (bit_tick)
   );

   always_ff @(posedge i_Clock or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         state       <= IDLE;
         shift_reg   <= 8'h00;
         n_lat       <= 11'(CLKS_PER_BIT_9600);
         bit_idx     <= 3'd0;
         o_Tx_Serial <= 1'b1;
         o_Tx_Active <= 1'b0;
         o_Tx_Done   <= 1'b0;
         o_Tx_Ready  <= 1'b1;
      end else begin
         o_Tx_Done <= 1'b0;
         case (state)
            IDLE: begin
               if (i_Tx_DV) begin
                  shift_reg   <= i_Tx_Byte;
                  n_lat       <= baud_clks(baud_select, CLKS_PER_BIT_9600, CLKS_PER_BIT_19200,
                                           CLKS_PER_BIT_38400, CLKS_PER_BIT_57600);
                  bit_idx     <= 3'd0;
                  state       <= START;
                  o_Tx_Serial <= 1'b0;
                  o_Tx_Active <= 1'b1;
                  o_Tx_Ready  <= 1'b0;
               end
            end
            START: begin
               if (bit_tick) begin
                  state       <= DATA;
                  o_Tx_Serial <= shift_reg[0];
               end
            end
            DATA: begin
               if (bit_tick) begin
                  if (bit_idx == 3'd7) begin
                     bit_idx     <= 3'd0;
`ifdef UART_TX_PARITY_EN
                     state       <= PARITY;
                     o_Tx_Serial <= (^shift_reg) ^ PARITY_ODD;
`else
                     state       <= STOP;
                     o_Tx_Serial <= 1'b1;
`endif
                  end else begin
                     bit_idx     <= bit_idx + 3'd1;
                     o_Tx_Serial <= shift_reg[bit_idx + 3'd1];
                  end
               end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
               if (bit_tick) begin
                  state       <= STOP;
                  o_Tx_Serial <= 1'b1;
               end
            end
`endif
            STOP: begin
               if (bit_tick) begin
                  state       <= CLEANUP;
                  o_Tx_Active <= 1'b0;
                  o_Tx_Done   <= 1'b1;
               end
            end
            CLEANUP: begin
               state      <= IDLE;
               o_Tx_Ready <= 1'b1;
            end
            default: begin
               state       <= IDLE;
               o_Tx_Serial <= 1'b1;
               o_Tx_Active <= 1'b0;
               o_Tx_Ready  <= 1'b1;
            end
         endcase
      end
   end

   // The bit counter must never run past the latched bit length.
   a_cnt_in_range: assert property (@(posedge i_Clock) disable iff (!i_Rst_L) bit_cnt < n_lat);

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: cycle-exact frame model built from the frame timing formulas.
module tb_uart_tx;

   localparam bit P_ODD = 1'b0;
`ifdef UART_TX_PARITY_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif

   logic       i_Clock = 1'b0;
   logic       i_Rst_L;
   logic       i_Tx_DV;
   logic [7:0] i_Tx_Byte;
   logic [1:0] baud_select;
   logic       o_Tx_Serial, o_Tx_Active, o_Tx_Done, o_Tx_Ready;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;

   always #5 i_Clock = ~i_Clock;

   uart_tx #(.PARITY_ODD(P_ODD)) dut (
      .i_Clock     (i_Clock),
      .i_Rst_L     (i_Rst_L),
      .i_Tx_DV     (i_Tx_DV),
      .i_Tx_Byte   (i_Tx_Byte),
      .baud_select (baud_select),
      .o_Tx_Serial (o_Tx_Serial),
      .o_Tx_Active (o_Tx_Active),
      .o_Tx_Done   (o_Tx_Done),
      .o_Tx_Ready  (o_Tx_Ready)
   );

   always @(negedge i_Clock) if (o_Tx_Done === 1'b1) done_cnt++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   // Called at a negedge with the DUT idle. Accept happens at the next posedge (t);
   // cycle c is the one following edge t+c-1, sampled at its negedge.
   task automatic run_frame(input string tag, input logic [7:0] b, input logic [1:0] sel,
                            input int n, input int poke_c, input int poke_len,
                            input logic [7:0] poke_b, input logic [1:0] poke_sel,
                            input logic poke_dv);
      int nb, last, slot, bs, ba, bd, br, done_at;
      logic es;
      nb = PAR ? 11 : 10;
      last = nb * n;
      bs = 0; ba = 0; bd = 0; br = 0; done_at = -1;
      check({tag, "_ready_pre"}, o_Tx_Ready, 1);
      i_Tx_Byte = b;
      baud_select = sel;
      i_Tx_DV = 1'b1;
      @(posedge i_Clock);
      for (int c = 1; c <= last + 2; c++) begin
         @(negedge i_Clock);
         if (c == 1) i_Tx_DV = 1'b0;
         if (c == poke_c) begin
            i_Tx_Byte = poke_b;
            baud_select = poke_sel;
            i_Tx_DV = poke_dv;
         end
         if (c == poke_c + poke_len) i_Tx_DV = 1'b0;
         slot = (c - 1) / n;
         if (c > last)            es = 1'b1;
         else if (slot == 0)      es = 1'b0;
         else if (slot <= 8)      es = b[slot-1];
         else if (PAR && slot == 9) es = (^b) ^ P_ODD;
         else                     es = 1'b1;
         if (o_Tx_Serial !== es) bs++;
         if (o_Tx_Active !== (c <= last)) ba++;
         if (o_Tx_Done === 1'b1 && done_at < 0) done_at = c;
         if (o_Tx_Done !== (c == last + 1)) bd++;
         if (o_Tx_Ready !== (c == last + 2)) br++;
      end
      check({tag, "_serial_bad_cycles"}, bs, 0);
      check({tag, "_active_bad_cycles"}, ba, 0);
      check({tag, "_done_bad_cycles"}, bd, 0);
      check({tag, "_ready_bad_cycles"}, br, 0);
      check({tag, "_done_cycle"}, done_at, last + 1);
   endtask

   initial begin
      int bad, d0, act;
      i_Rst_L = 1'b0;
      i_Tx_DV = 1'b1;
      i_Tx_Byte = 8'hA5;
      baud_select = 2'b00;

      // Reset held with DV asserted: line stays idle.
      bad = 0;
      repeat (20) begin
         @(negedge i_Clock);
         if (o_Tx_Serial !== 1'b1 || o_Tx_Ready !== 1'b1 ||
             o_Tx_Active !== 1'b0 || o_Tx_Done !== 1'b0) bad++;
      end
      check("reset_hold_bad_cycles", bad, 0);
      check("reset_serial", o_Tx_Serial, 1);
      check("reset_ready", o_Tx_Ready, 1);
      check("reset_active", o_Tx_Active, 0);
      check("reset_done", o_Tx_Done, 0);
      i_Tx_DV = 1'b0;
      @(negedge i_Clock);
      i_Rst_L = 1'b1;
      repeat (3) @(negedge i_Clock);
      check("post_reset_idle_serial", o_Tx_Serial, 1);

      // 0xA5 at 9600.
      run_frame("a5_b00", 8'hA5, 2'b00, 1042, 0, 0, 8'h00, 2'b00, 1'b0);

      // Back-to-back 0xFF then 0x00 at 57600 with DV held.
      d0 = done_cnt;
      run_frame("ff_b11", 8'hFF, 2'b11, 174, 1, 100000, 8'h00, 2'b11, 1'b1);
      run_frame("00_b11", 8'h00, 2'b11, 174, 0, 0, 8'h00, 2'b11, 1'b0);
      check("b2b_done_pulses", done_cnt - d0, 2);

      // Busy-time DV pulse at 38400 is dropped.
      run_frame("81_b10", 8'h81, 2'b10, 261, 500, 1, 8'h3C, 2'b10, 1'b1);
      act = 0;
      repeat (30) begin
         @(negedge i_Clock);
         if (o_Tx_Active !== 1'b0 || o_Tx_Serial !== 1'b1) act++;
      end
      check("dropped_byte_no_frame", act, 0);

      // Mid-frame baud change applies only to the next frame.
      run_frame("96_b00_chg", 8'h96, 2'b00, 1042, 3000, 0, 8'h96, 2'b11, 1'b0);
      run_frame("3c_b11_next", 8'h3C, 2'b11, 174, 0, 0, 8'h00, 2'b11, 1'b0);

      // Reset during data bit 3 (cycles 697..870 at N=174).
      i_Tx_Byte = 8'hC3;
      baud_select = 2'b11;
      i_Tx_DV = 1'b1;
      @(posedge i_Clock);
      for (int c = 1; c <= 750; c++) begin
         @(negedge i_Clock);
         if (c == 1) i_Tx_DV = 1'b0;
      end
      check("midrst_bit3_before", o_Tx_Serial, 0);
      d0 = done_cnt;
      i_Rst_L = 1'b0;
      #1;
      check("midrst_serial_async", o_Tx_Serial, 1);
      check("midrst_active_async", o_Tx_Active, 0);
      check("midrst_ready_async", o_Tx_Ready, 1);
      repeat (5) @(negedge i_Clock);
      i_Rst_L = 1'b1;
      repeat (200) @(negedge i_Clock);
      check("midrst_no_done", done_cnt - d0, 0);
      run_frame("5a_after_rst", 8'h5A, 2'b11, 174, 0, 0, 8'h00, 2'b11, 1'b0);

`ifdef UART_TX_PARITY_EN
      run_frame("07_parity", 8'h07, 2'b11, 174, 0, 0, 8'h00, 2'b11, 1'b0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_tx.md
# uart_tx

Byte-wide UART transmitter, the transmit-side counterpart of the team's 8N1 UART receiver. It has the same four selectable baud rates and the same clocks-per-bit constants. It accepts one byte per handshake, serialises it LSB-first with a start bit and a stop bit, and reports busy, done and ready status. It sits between the host-side byte source and the serial TX pin.

## Interface
Parameters:
- CLKS_PER_BIT_9600, 1042, clocks per bit for baud_select 2'b00
- CLKS_PER_BIT_19200, 521, clocks per bit for 2'b01
- CLKS_PER_BIT_38400, 261, clocks per bit for 2'b10
- CLKS_PER_BIT_57600, 174, clocks per bit for 2'b11
- PARITY_ODD, 0, parity sense when parity is compiled in: 0 = even, 1 = odd

Ports (one clock; reset is asynchronous and active-low):
- i_Clock  input  1  system clock
- i_Rst_L  input  1  asynchronous active-low reset
- i_Tx_DV  input  1  byte valid; sampled only while o_Tx_Ready=1
- i_Tx_Byte  input  8  byte to send
- baud_select  input  2  baud rate selection; latched at frame acceptance
- o_Tx_Serial  output  1  serial line; idles high
- o_Tx_Active  output  1  high from the start bit through the end of the stop bit
- o_Tx_Done  output  1  one-cycle pulse after the stop bit completes
- o_Tx_Ready  output  1  high only in IDLE

## Operation
- States and transitions:
  - IDLE → START when i_Tx_DV=1 (accept).
  - START → DATA.
  - DATA → PARITY (macro defined) or STOP.
  - PARITY → STOP.
  - STOP → CLEANUP.
  - CLEANUP → IDLE.
- On accept: latch i_Tx_Byte into a shift register and the per-bit cycle count N from baud_select. Mapping: 00→1042, 01→521, 10→261, 11→174.
- Later changes to i_Tx_Byte or baud_select do not affect the frame in flight.
- Every serial bit is held exactly N cycles.
- Bit timer: 11-bit counter, counts 0..N-1 and wraps to 0 at N-1; the bit-end tick is asserted at N-1.
- Bit index: 3 bits, 0..7. It wraps to 0 after bit 7, and the state advances.
- o_Tx_Serial per state: IDLE 1, START 0, DATA shift_reg[bit index], STOP 1, CLEANUP 1.
- i_Tx_DV outside IDLE is ignored, with no queuing; the byte is lost.
- Reset values: o_Tx_Serial=1, o_Tx_Active=0, o_Tx_Done=0, o_Tx_Ready=1. State is IDLE, and the counter and bit index are 0.
- Reset asserted mid-frame: the line returns high immediately (asynchronous) and the frame is abandoned, with no o_Tx_Done.

## Timing
Let cycle t be the edge at which i_Tx_DV=1 is sampled in IDLE. All outputs are registered.
- t+1: o_Tx_Serial=0, o_Tx_Active=1, o_Tx_Ready=0.
- Data bit k (k = 0..7) is driven on cycles t+1+(k+1)N through t+(k+2)N.
- Stop bit is driven on cycles t+1+9N through t+10N.
- t+10N+1: o_Tx_Done=1 for one cycle, o_Tx_Active=0, line high.
- t+10N+2: o_Tx_Ready=1. The earliest next accept is at this edge, so the next start bit appears at t+10N+3.
- Minimum frame period is 10N+2 cycles (11N+2 with parity).

## Configuration
- Macro UART_TX_PARITY_EN.
- Defined: the PARITY state inserts one bit of N cycles between data bit 7 and the stop bit. The bit value is the XOR of the 8 latched data bits, XORed with PARITY_ODD. All timing after the data bits shifts by N cycles.
- Undefined: 8N1 only. The PARITY state and its logic are absent, and PARITY_ODD has no effect.

## Structure
- Shared package uart_pkg holds:
  - the state encoding (3-bit localparams IDLE/START/DATA/PARITY/STOP/CLEANUP);
  - the four CLKS_PER_BIT constants;
  - the baud_select→cycles function.
- The receiver uses the same package.
- One sub-module, uart_bit_timer. Inputs: clock, reset, enable, 11-bit N. Outputs: the count and a bit-end tick at N-1.

## Test plan
- Reset: hold i_Rst_L=0 with i_Tx_DV=1 → o_Tx_Serial=1, o_Tx_Ready=1, Active=0, Done=0 throughout; nothing is transmitted until release.
- baud_select=00, send 0xA5 → start at t+1. Line sequence is 0,1,0,1,0,0,1,0,1,1, each held exactly 1042 cycles. Done pulses at t+10421.
- baud_select=11, send 0xFF, then 0x00 with i_Tx_DV held high → each frame is 1740 active cycles. Second start bit at t+1743. Exactly two Done pulses.
- Pulse i_Tx_DV with 0x3C at t+500 during a 0x81 frame at baud 10 → ignored. Only 0x81 is transmitted and Ready stays 0 until t+2612.
- Change baud_select from 00 to 11 mid-frame → all bits of the frame stay 1042 cycles; the next frame uses 174.
- Assert i_Rst_L=0 during data bit 3 → line high within the same cycle, no Done pulse. After release, 0x5A transmits correctly.
- With UART_TX_PARITY_EN, PARITY_ODD=0, send 0x07 → parity bit 1, frame 11N. With PARITY_ODD=1 → parity bit 0.
